// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Raster scan controller that sits after the frame buffer. It runs the
//   horizontal/vertical timing counters, issues buffer reads for an
//   IMG_W x IMG_H image anchored at the top-left of the active area, and
//   drives RGB (buffer pixel or border colour) aligned with hsync/vsync/de.
//   vblank tells the upstream writer when the buffer is not being read.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           scan enable (sampled in IDLE and on the last pixel of a frame)
//   R_in/G_in/B_in  pixel returned by the buffer, one cycle after RE
//   RE, Addr     buffer read enable / read address
//   R, G, B      pixel to the display
//   hsync, vsync active-low sync pulses
//   de           data enable (active area)
//   vblank       high while the buffer is free for writes
//   frame_start  one-cycle pulse with the first de cycle of a frame
module display_scan_ctrl #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned IMG_W      = 100,
  parameter int unsigned IMG_H      = 100,
  parameter int unsigned ADDR_W     = 20,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [7:0]        R_in,
  input  logic [7:0]        G_in,
  input  logic [7:0]        B_in,
  output logic              RE,
  output logic [ADDR_W-1:0] Addr,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              vblank,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     h, h_nxt;
  logic [VW-1:0]     v, v_nxt;
  logic [ADDR_W-1:0] addr_cnt, addr_sel;
  logic              scan, rd, act, hs_n, vs_n, fs;
  // Stage 1/2 copies of the per-pixel flags, keeping them aligned with the
  // buffer's read latency.
  logic              img1, img2, de1, de2, hs1, hs2, vs1, vs2, fs1, fs2;

  always_comb begin
    state_nxt = state;
    h_nxt     = '0;
    v_nxt     = '0;
    scan      = (state == SCAN);
    if (scan) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + VW'(1);
        if (v == V_LAST && !en) state_nxt = IDLE;
      end else begin
        h_nxt = h + HW'(1);
        v_nxt = v;
      end
    end else if (en) begin
      state_nxt = SCAN;
    end
    rd       = scan && (h < H_IMG) && (v < V_IMG);
    act      = scan && (h < H_ACT) && (v < V_ACT);
    hs_n     = !(scan && (h >= H_SS) && (h < H_SE));
    vs_n     = !(scan && (v >= V_SS) && (v < V_SE));
    fs       = scan && (h == '0) && (v == '0);
    addr_sel = ((h == '0) && (v == '0)) ? '0 : addr_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      h           <= '0;
      v           <= '0;
      addr_cnt    <= '0;
      RE          <= 1'b0;
      Addr        <= '0;
      vblank      <= 1'b1;
      img1        <= 1'b0;
      img2        <= 1'b0;
      de1         <= 1'b0;
      de2         <= 1'b0;
      hs1         <= 1'b1;
      hs2         <= 1'b1;
      vs1         <= 1'b1;
      vs2         <= 1'b1;
      fs1         <= 1'b0;
      fs2         <= 1'b0;
      {B, G, R}   <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state  <= state_nxt;
      h      <= h_nxt;
      v      <= v_nxt;
      // Computed from the next counter position so vblank drops one cycle
      // ahead of the first read of a frame and rises right after the last.
      vblank <= (state_nxt == IDLE) || (v_nxt >= V_IMG);
      if (state_nxt == IDLE) begin
        // Entering/holding IDLE forces reset values on every output; the
        // pipeline tail at frame end is blanking only, so no pixel is lost.
        addr_cnt    <= '0;
        RE          <= 1'b0;
        Addr        <= '0;
        img1        <= 1'b0;
        img2        <= 1'b0;
        de1         <= 1'b0;
        de2         <= 1'b0;
        hs1         <= 1'b1;
        hs2         <= 1'b1;
        vs1         <= 1'b1;
        vs2         <= 1'b1;
        fs1         <= 1'b0;
        fs2         <= 1'b0;
        {B, G, R}   <= '0;
        hsync       <= 1'b1;
        vsync       <= 1'b1;
        de          <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        RE <= rd;
        if (rd) begin
          Addr     <= addr_sel;
          addr_cnt <= addr_sel + ADDR_W'(1);
        end
        img1 <= rd;
        de1  <= act;
        hs1  <= hs_n;
        vs1  <= vs_n;
        fs1  <= fs;
        img2 <= img1;
        de2  <= de1;
        hs2  <= hs1;
        vs2  <= vs1;
        fs2  <= fs1;
        if (de2 && img2) begin
          {B, G, R} <= {B_in, G_in, R_in};
        end else if (de2) begin
          {B, G, R} <= BORDER_RGB;
        end else begin
          {B, G, R} <= '0;
        end
        hsync       <= hs2;
        vsync       <= vs2;
        de          <= de2;
        frame_start <= fs2;
      end
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Raster scan controller directly downstream of the frame buffer (Buf1 stage).
- Generates the display timing counters and issues read enable plus read address to the buffer for a rectangular image at the top-left of the active area.
- Muxes returned buffer pixels or a border colour onto the RGB outputs, aligned with hsync/vsync/de.
- Drives a vblank flag so the upstream writer knows when it may write the buffer without colliding with reads.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_W, 100, image width in pixels (≤ H_ACTIVE)
- IMG_H, 100, image height in lines (≤ V_ACTIVE)
- ADDR_W, 20, buffer address width
- BORDER_RGB, 24'h000000, colour outside image, {B,G,R}

Ports:
- clk, in, 1, system clock, rising edge
- reset, in, 1, asynchronous active-low reset
- en, in, 1, scan enable
- R_in, in, 8, red from buffer
- G_in, in, 8, green from buffer
- B_in, in, 8, blue from buffer
- RE, out, 1, buffer read enable
- Addr, out, ADDR_W, buffer read address
- R, out, 8, red to display
- G, out, 8, green to display
- B, out, 8, blue to display
- hsync, out, 1, horizontal sync, active-low
- vsync, out, 1, vertical sync, active-low
- de, out, 1, data enable (active area)
- vblank, out, 1, high when buffer is free for writes
- frame_start, out, 1, one-cycle pulse at pixel (0,0)

Behaviour:
- Reset (reset=0, async): state=IDLE, h=v=0, addr counter=0.
  - Outputs: RE=0, Addr=0, R=G=B=0, hsync=1, vsync=1, de=0, vblank=1, frame_start=0.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL analogous.
- h counts 0..H_TOTAL-1 and wraps to 0; v increments on each h wrap and wraps at V_TOTAL-1.
- FSM states:
  - IDLE: counters held at 0, all outputs at reset values. Moves to SCAN on the first cycle en=1.
  - SCAN: counters run. en is sampled only on the last pixel of a frame (h=H_TOTAL-1, v=V_TOTAL-1). If en=0 there, go to IDLE at the next edge; otherwise continue with the next frame. Deasserting en mid-frame never truncates the frame.
- Pipeline (cycle n = counter value (h,v)):
  - n+1: RE and Addr registered. RE=1 iff SCAN, h<IMG_W and v<IMG_H; otherwise RE=0 and Addr holds its last value.
  - n+2: buffer data valid on R_in/G_in/B_in (one-cycle buffer read latency).
  - n+3: R/G/B, hsync, vsync, de and frame_start registered together. Timing signals are delayed 3 cycles to stay aligned with pixel data.
- Address generation is incremental, with no multiplier:
  - addr counter resets to 0 at h=0, v=0.
  - It increments by 1 on each cycle RE is issued, so the pixel at (h,v) reads address v*IMG_W+h.
  - The last image pixel reads IMG_W*IMG_H-1. The counter does not wrap within a frame.
- Pixel mux at n+3: if de and the delayed in-image flag are set, RGB = R_in/G_in/B_in. Else if de, RGB = BORDER_RGB. Else RGB = 0.
- hsync=0 when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. vsync=0 on the analogous v range. de=1 when h<H_ACTIVE and v<V_ACTIVE. All three are delayed 3 cycles as above.
- vblank = (state==IDLE) or (v ≥ IMG_H), registered at n+1.
  - vblank falls one cycle before the first RE of a frame.
  - RE is never 1 while vblank=1.
- frame_start is high for exactly one cycle per frame, aligned with the first de cycle.
- Reset asserted mid-frame: all outputs immediately take reset values (async). After release, scanning restarts from (0,0) in IDLE and waits for en.

Test Plan (sim params: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, IMG_W=4, IMG_H=2, BORDER_RGB=24'h0000FF):
- Reset then en=1; buffer model returns data = address -> first frame RE pulses at Addr 0..3 on line 0 and 4..7 on line 1; 8 RE cycles total per frame.
- Check timing -> hsync low for 2 clocks at h=9..10 (observed 3 cycles late); vsync low for line 5; line period 12 clocks; frame period 84 clocks; frame_start once per 84 clocks.
- Pixel alignment -> on line 0, R outputs 0,1,2,3 then R=8'hFF for 4 de cycles (border), with de=1 for 8 cycles, then RGB=0 in blanking.
- Drop en at line 1 -> current frame completes through v=6. At the next edge: IDLE, RE=0, vblank=1, hsync=vsync=1. Re-raise en -> Addr restarts at 0.
- vblank check -> vblank=1 from line 2 through frame end. RE=0 whenever vblank=1. vblank falls exactly 1 cycle before the Addr=0 read.
- Assert reset mid-line 1 -> same cycle: RGB=0, de=0, RE=0, hsync=vsync=1, vblank=1. After release with en=1 -> first read at Addr 0.
